// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the 5-stage pipeline run-control / hazard unit.
//   run_state_t : run-control FSM states
//   fwd_sel_t   : EX operand source select (regfile / MEM alu_out / WB data)
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

endpackage : pipe_pkg

// File: rtl/forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Combinational operand-forwarding select for one EX source operand.
// The younger producer (MEM) wins over the older one (WB).
// Ports:
//   ex_valid_i      EX stage holds a real instruction
//   ex_rs_i         source register of this operand
//   mem_valid_i     MEM stage holds a real instruction
//   mem_reg_write_i MEM instruction writes the register file
//   mem_rd_i        MEM destination register
//   wb_valid_i      WB stage holds a real instruction
//   wb_reg_write_i  WB instruction writes the register file
//   wb_rd_i         WB destination register
//   fwd_sel_o       00 regfile, 01 MEM alu_out, 10 WB data
// -----------------------------------------------------------------------------
module forward_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic              mem_valid_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              wb_valid_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    output logic [1:0]        fwd_sel_o
);

    fwd_sel_t sel;

    // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel = FWD_RF;
        if (ex_valid_i) begin
            if (mem_valid_i && mem_reg_write_i && (mem_rd_i == ex_rs_i)) begin
                sel = FWD_MEM;
            end else if (wb_valid_i && wb_reg_write_i && (wb_rd_i == ex_rs_i)) begin
                sel = FWD_WB;
            end
        end
    end

    assign fwd_sel_o = sel;

endmodule : forward_unit

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Run-control and hazard unit for a 5-stage (IF/ID/EX/MEM/WB) pipeline.
// Gates fetch on start, tracks per-stage valid bits, inserts load-use stalls,
// flushes on taken branches, selects EX forwarding, drains on HALT and counts
// busy cycles and retired instructions.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       run request (sampled in IDLE/DONE)
//   id_rs1/2, id_use_rs1/2      ID source regs and their use flags
//   id_halt                     ID instruction is HALT
//   ex_rs1/2, ex_rd             EX source / destination regs
//   ex_mem_read                 EX instruction is a load
//   ex_branch_taken             EX resolved a taken branch/jump
//   mem_rd, mem_reg_write       MEM destination and write flag
//   wb_rd, wb_reg_write         WB destination and write flag
//   pc_en, pc_clr               PC load enable, one-cycle PC clear at run start
//   if_id_en, if_id_flush       IF/ID load enable, IF/ID bubble insert
//   id_ex_flush                 ID/EX bubble insert
//   fwd_a, fwd_b                EX operand selects (00 RF, 01 MEM, 10 WB)
//   busy, done                  state is RUN/DRAIN, state is DONE
//   cycle_cnt, retired_cnt      saturating busy-cycle and retire counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 4,
    parameter int CNT_W   = 32,
    parameter int DRAIN_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_halt,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    output logic              pc_en,
    output logic              pc_clr,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam int DCW = (DRAIN_N < 1) ? 1 : $clog2(DRAIN_N + 1);

    run_state_t       state_q, state_d;
    logic             v_id_q, v_id_d, v_ex_q, v_ex_d;
    logic             v_mem_q, v_mem_d, v_wb_q, v_wb_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    logic stall, branch, halt_ok, busy_c, clr_cnt;

    // Branch outranks both the load-use stall and a HALT sitting in ID.
    assign branch  = v_ex_q & ex_branch_taken;
    assign stall   = v_ex_q & ex_mem_read &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign halt_ok = v_id_q & id_halt & ~branch & ~stall;
    assign busy_c  = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        v_id_d      = 1'b0;
        v_ex_d      = 1'b0;
        v_mem_d     = 1'b0;
        v_wb_d      = 1'b0;
        pc_en       = 1'b0;
        pc_clr      = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        clr_cnt     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !rst) begin
                    state_d = ST_RUN;
                    pc_clr  = 1'b1;
                    clr_cnt = 1'b1;
                end
            end
            ST_RUN: begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b0;
                id_ex_flush = 1'b0;
                v_mem_d     = v_ex_q;
                v_wb_d      = v_mem_q;
                if (branch) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (stall) begin
                    // Hold PC and IF/ID; the load moves on and EX gets one bubble.
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    v_id_d      = v_id_q;
                end else if (halt_ok) begin
                    // HALT never enters EX; whatever was fetched behind it is dead.
                    id_ex_flush = 1'b1;
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DCW'(DRAIN_N);
                end else begin
                    v_id_d = 1'b1;
                    v_ex_d = v_id_q;
                end
            end
            ST_DRAIN: begin
                // Fetch stays frozen; branches here are older than HALT and are not redirected.
                v_mem_d = v_ex_q;
                v_wb_d  = v_mem_q;
                // Leave on the cycle the counter reaches zero, giving DRAIN_N drain cycles.
                if (drain_cnt_q <= DCW'(1)) begin
                    drain_cnt_d = '0;
                    state_d     = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cycle_cnt_d   = cycle_cnt_q;
        retired_cnt_d = retired_cnt_q;
        if (clr_cnt) begin
            cycle_cnt_d   = '0;
            retired_cnt_d = '0;
        end else begin
            if (busy_c && (cycle_cnt_q != '1)) begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end
            if (v_wb_q && (retired_cnt_q != '1)) begin
                retired_cnt_d = retired_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            v_id_q        <= 1'b0;
            v_ex_q        <= 1'b0;
            v_mem_q       <= 1'b0;
            v_wb_q        <= 1'b0;
            drain_cnt_q   <= '0;
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            v_id_q        <= v_id_d;
            v_ex_q        <= v_ex_d;
            v_mem_q       <= v_mem_d;
            v_wb_q        <= v_wb_d;
            drain_cnt_q   <= drain_cnt_d;
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_valid_i      (v_ex_q),
        .ex_rs_i         (ex_rs1),
        .mem_valid_i     (v_mem_q),
        .mem_reg_write_i (mem_reg_write),
        .mem_rd_i        (mem_rd),
        .wb_valid_i      (v_wb_q),
        .wb_reg_write_i  (wb_reg_write),
        .wb_rd_i         (wb_rd),
        .fwd_sel_o       (fwd_a)
    );

    forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_valid_i      (v_ex_q),
        .ex_rs_i         (ex_rs2),
        .mem_valid_i     (v_mem_q),
        .mem_reg_write_i (mem_reg_write),
        .mem_rd_i        (mem_rd),
        .wb_valid_i      (v_wb_q),
        .wb_reg_write_i  (wb_reg_write),
        .wb_rd_i         (wb_rd),
        .fwd_sel_o       (fwd_b)
    );

    assign busy        = busy_c;
    assign done        = (state_q == ST_DONE);
    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. The stimulus process drives one cycle
// of inputs at a time and queues the hand-computed expected outputs for that
// cycle; a separate monitor pops one entry per cycle on the falling edge and
// compares. Control outputs are packed as
// {pc_en,pc_clr,if_id_en,if_id_flush,id_ex_flush,fwd_a,fwd_b,busy,done}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REG_AW  = 4;
    localparam int CNT_W   = 32;
    localparam int DRAIN_N = 3;

    logic              clk;
    logic              rst;
    logic              start;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic              id_use_rs1, id_use_rs2, id_halt;
    logic              ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write;
    logic              pc_en, pc_clr, if_id_en, if_id_flush, id_ex_flush;
    logic [1:0]        fwd_a, fwd_b;
    logic              busy, done;
    logic [CNT_W-1:0]  cycle_cnt, retired_cnt;

    pipe_hazard_ctrl #(
        .REG_AW  (REG_AW),
        .CNT_W   (CNT_W),
        .DRAIN_N (DRAIN_N)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_halt         (id_halt),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .mem_reg_write   (mem_reg_write),
        .wb_reg_write    (wb_reg_write),
        .pc_en           (pc_en),
        .pc_clr          (pc_clr),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .busy            (busy),
        .done            (done),
        .cycle_cnt       (cycle_cnt),
        .retired_cnt     (retired_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected control vectors
    localparam logic [10:0] C_IDLE    = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [10:0] C_START   = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [10:0] C_RUN     = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [10:0] C_STALL   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [10:0] C_BRANCH  = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [10:0] C_HALT    = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [10:0] C_DRAIN   = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [10:0] C_DONE    = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
    localparam logic [10:0] C_DONE_ST = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};

    function automatic logic [10:0] run_fwd(input logic [1:0] fa, input logic [1:0] fb);
        return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, fa, fb, 1'b1, 1'b0};
    endfunction

    typedef struct {
        string       name;
        bit          chk_ctl;
        logic [10:0] ctl;
        bit          chk_cnt;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Queue the expectation for the cycle whose inputs are now driven, then advance one cycle.
    task automatic step(input string name, input bit chk_ctl, input logic [10:0] ctl,
                        input bit chk_cnt, input logic [31:0] c, input logic [31:0] r);
        exp_t e;
        e.name    = name;
        e.chk_ctl = chk_ctl;
        e.ctl     = ctl;
        e.chk_cnt = chk_cnt;
        e.cyc     = c;
        e.ret     = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [10:0] ctl);
        step(name, 1'b1, ctl, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic chkc(input string name, input logic [10:0] ctl,
                        input logic [31:0] c, input logic [31:0] r);
        step(name, 1'b1, ctl, 1'b1, c, r);
    endtask

    task automatic defaults();
        id_rs1          = '0;
        id_rs2          = '0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        id_halt         = 1'b0;
        ex_rs1          = '0;
        ex_rs2          = '0;
        ex_rd           = '0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        mem_rd          = '0;
        wb_rd           = '0;
        mem_reg_write   = 1'b0;
        wb_reg_write    = 1'b0;
    endtask

    // Reset for three cycles (start held high in the last one), then start a run.
    // Ends at the beginning of the second RUN cycle.
    task automatic reset_and_start();
        defaults();
        rst   = 1'b1;
        start = 1'b0;
        step("rst_enter", 1'b0, '0, 1'b0, 32'd0, 32'd0);
        chkc("rst_idle_a", C_IDLE, 32'd0, 32'd0);
        start = 1'b1;
        chkc("rst_start_ignored", C_IDLE, 32'd0, 32'd0);
        rst = 1'b0;
        chkc("start_pc_clr", C_START, 32'd0, 32'd0);
        start = 1'b0;
        chkc("run_first", C_RUN, 32'd0, 32'd0);
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    initial begin : monitor
        exp_t        e;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                act = {pc_en, pc_clr, if_id_en, if_id_flush, id_ex_flush, fwd_a, fwd_b, busy, done};
                if (e.chk_ctl) begin
                    checks++;
                    if (act !== e.ctl) begin
                        errors++;
                        $display("FAIL %s ctl got %b expected %b (pe,clr,ie,iff,ief,fa,fb,busy,done) t=%0t",
                                 e.name, act, e.ctl, $time);
                    end
                end
                if (e.chk_cnt) begin
                    checks++;
                    if (cycle_cnt !== e.cyc) begin
                        errors++;
                        $display("FAIL %s cycle_cnt got %0d expected %0d", e.name, cycle_cnt, e.cyc);
                    end
                    checks++;
                    if (retired_cnt !== e.ret) begin
                        errors++;
                        $display("FAIL %s retired_cnt got %0d expected %0d", e.name, retired_cnt, e.ret);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        rst   = 1'b1;
        start = 1'b0;
        defaults();
        @(posedge clk);
        #1;

        // ---- Run A: load-use, forwarding, branch priority ----
        reset_and_start();                       // now in R2
        chkc("lw_in_id", C_RUN, 32'd1, 32'd0);    // R2
        // R3: LW r2 in EX, ADD r3,r2,r1 in ID
        ex_mem_read = 1'b1; ex_rd = 4'd2; ex_rs1 = 4'd5;
        id_rs1 = 4'd2; id_use_rs1 = 1'b1; id_rs2 = 4'd1; id_use_rs2 = 1'b1;
        chk("loaduse_stall", C_STALL);
        // R4: bubble in EX, LW in MEM, ADD still in ID
        defaults();
        id_rs1 = 4'd2; id_use_rs1 = 1'b1; id_rs2 = 4'd1; id_use_rs2 = 1'b1;
        mem_rd = 4'd2; mem_reg_write = 1'b1;
        chk("loaduse_bubble", C_RUN);
        // R5: ADD in EX, bubble in MEM (stale rd=2 must be ignored), LW in WB
        defaults();
        ex_rs1 = 4'd2; ex_rs2 = 4'd1;
        mem_rd = 4'd2; mem_reg_write = 1'b1;
        wb_rd  = 4'd2; wb_reg_write  = 1'b1;
        chk("loaduse_fwd_wb", run_fwd(2'b10, 2'b00));
        // R6: ADD r1 in EX, nothing to forward
        defaults();
        chk("add_r1_ex", C_RUN);
        // R7: SUB r4,r1,r1 in EX, ADD r1 in MEM
        ex_rs1 = 4'd1; ex_rs2 = 4'd1;
        mem_rd = 4'd1; mem_reg_write = 1'b1;
        wb_rd  = 4'd3; wb_reg_write  = 1'b1;
        chk("b2b_fwd_mem", run_fwd(2'b01, 2'b01));
        // R8: operand A from MEM, operand B from WB
        defaults();
        ex_rs1 = 4'd4; ex_rs2 = 4'd1;
        mem_rd = 4'd4; mem_reg_write = 1'b1;
        wb_rd  = 4'd1; wb_reg_write  = 1'b1;
        chk("fwd_mem_and_wb", run_fwd(2'b01, 2'b10));
        // R9: MEM and WB both write r5: MEM wins
        defaults();
        ex_rs1 = 4'd5; ex_rs2 = 4'd5;
        mem_rd = 4'd5; mem_reg_write = 1'b1;
        wb_rd  = 4'd5; wb_reg_write  = 1'b1;
        chk("mem_over_wb", run_fwd(2'b01, 2'b01));
        // R10: load in EX, ID names r6 but does not read it
        defaults();
        ex_mem_read = 1'b1; ex_rd = 4'd6; id_rs1 = 4'd6; id_rs2 = 4'd6;
        chk("no_use_no_stall", C_RUN);
        // R11: same, now rs2 is used
        id_use_rs2 = 1'b1;
        chk("stall_rs2", C_STALL);
        // R12: inputs unchanged, EX now a bubble: only one stall cycle
        chk("one_bubble_only", C_RUN);
        // R13: taken branch with HALT in ID and a load-use match: branch wins
        defaults();
        ex_branch_taken = 1'b1; id_halt = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 4'd6; id_rs1 = 4'd6; id_use_rs1 = 1'b1;
        chkc("branch_over_halt_stall", C_BRANCH, 32'd12, 32'd7);
        // R14: ID and EX squashed; stale halt/branch inputs have no effect
        defaults();
        id_halt = 1'b1; ex_branch_taken = 1'b1;
        chk("halt_squashed", C_RUN);
        // R15
        defaults();
        chkc("counts_run_a", C_RUN, 32'd14, 32'd8);

        // ---- Run B: five ALU instrs, HALT, drain, done, restart ----
        reset_and_start();                       // now in R2
        for (int i = 0; i < 5; i++) begin
            chk("alu_stream", C_RUN);            // R2..R6
        end
        id_halt = 1'b1; start = 1'b1;
        chk("halt_beats_start", C_HALT);         // R7
        defaults(); start = 1'b0;
        chk("drain_1", C_DRAIN);                 // R8
        ex_branch_taken = 1'b1;
        chk("drain_2_branch_ignored", C_DRAIN);  // R9
        defaults();
        chk("drain_3", C_DRAIN);                 // R10
        chkc("done", C_DONE, 32'd10, 32'd5);     // R11
        chkc("done_hold", C_DONE, 32'd10, 32'd5);
        start = 1'b1;
        chkc("done_restart", C_DONE_ST, 32'd10, 32'd5);
        start = 1'b0;
        chkc("restart_run", C_RUN, 32'd0, 32'd0);

        // ---- Reset during DRAIN ----
        id_halt = 1'b1;
        chkc("halt_again", C_HALT, 32'd1, 32'd0);
        defaults();
        rst = 1'b1;
        chk("drain_with_rst", C_DRAIN);
        rst = 1'b0;
        chkc("rst_in_drain_idle", C_IDLE, 32'd0, 32'd0);
        start = 1'b1;
        chkc("restart_from_idle", C_START, 32'd0, 32'd0);
        start = 1'b0;
        chkc("restart_run_0", C_RUN, 32'd0, 32'd0);
        chkc("restart_run_1", C_RUN, 32'd1, 32'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
